cu_sequencer: RTL and testbench



---
 rtl/cu_sequencer_if.sv | 27 ++
 rtl/cu_sequencer.sv | 102 ++++++++++
 tb/tb_cu_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cu_sequencer_if.sv
// Bus between the sequencer, program memory and the 4-bit computational unit.
// The master side is the sequencer; the slave side is the memory/datapath.
interface cu_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] pm_addr;
  logic [7:0]      pm_data;
  logic            hold;
  logic            r_eq_0;
  logic [7:0]      ir;
  logic [3:0]      nibble_ir;
  logic [3:0]      source_sel;
  logic [8:0]      reg_en;
  logic            i_sel;
  logic            x_sel;
  logic            y_sel;

  modport master (
    input  pm_data, hold, r_eq_0,
    output pm_addr, ir, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel
  );

  modport slave (
    output pm_data, hold, r_eq_0,
    input  pm_addr, ir, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel
  );
endinterface

// File: rtl/cu_sequencer.sv
// Fetch/decode/branch controller: holds pc and ir, decodes ir into datapath
// controls, and inserts a one-cycle NOP bubble on every taken branch.
module cu_sequencer #(
  parameter int          PC_W     = 8,
  parameter logic [7:0]  NOP_WORD = 8'hC8
) (
  input  logic           clk,
  input  logic           sync_reset,
  cu_sequencer_if.master bus
);
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0] HI_MASK = {{(PC_W-4){1'b1}}, 4'h0};

  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;

  logic [2:0]      dst;
  logic [2:0]      src;
  logic [3:0]      source_sel;
  logic [8:0]      reg_en;
  logic            i_sel;
  logic            x_sel;
  logic            y_sel;
  logic            taken;
  logic [PC_W-1:0] target;

  assign dst = ir_q[7] ? ir_q[5:3] : ir_q[6:4];
  assign src = ir_q[2:0];
  // pc already points one past the instruction sitting in ir
  assign target = ((pc_q - PC_ONE) & HI_MASK) | {{(PC_W-4){1'b0}}, ir_q[3:0]};

  always_comb begin
    source_sel = 4'd10;
    reg_en     = 9'd0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    taken      = 1'b0;

    if (!ir_q[7] || ir_q[7:6] == 2'b10) begin
      if (!ir_q[7])
        source_sel = 4'd8;
      else if (dst == src)
        source_sel = 4'd9;
      else
        source_sel = {1'b0, src};

      case (dst)
        3'd4:    reg_en[8] = 1'b1;
        default: reg_en[dst] = 1'b1;
      endcase

      // Any dm access post-increments i, unless i itself is the destination
      if ((dst == 3'd7 || (ir_q[7] && src == 3'd7 && dst != src)) && dst != 3'd6) begin
        reg_en[6] = 1'b1;
        i_sel     = 1'b1;
      end
    end else if (ir_q[7:5] == 3'b110) begin
      x_sel     = ir_q[4];
      y_sel     = ir_q[3];
      reg_en[4] = !(ir_q[3] && (src == 3'd0 || src == 3'd7));
    end else if (ir_q[4]) begin
      taken = !bus.r_eq_0;
    end else begin
      taken = 1'b1;
    end

    if (bus.hold)
      reg_en = 9'd0;
  end

  always_comb begin
    pc_d = pc_q + PC_ONE;
    ir_d = bus.pm_data;
    if (bus.hold) begin
      pc_d = pc_q;
      ir_d = ir_q;
    end else if (taken) begin
      pc_d = target;
      ir_d = NOP_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q <= '0;
      ir_q <= NOP_WORD;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign bus.pm_addr    = pc_q;
  assign bus.ir         = ir_q;
  assign bus.nibble_ir  = ir_q[3:0];
  assign bus.source_sel = source_sel;
  assign bus.reg_en     = reg_en;
  assign bus.i_sel      = i_sel;
  assign bus.x_sel      = x_sel;
  assign bus.y_sel      = y_sel;
endmodule

// File: tb/tb_cu_sequencer.sv
// Directed bench for cu_sequencer: a 256-word program image drives pm_data
// combinationally; each scenario loads a small program and checks by hand.
module tb_cu_sequencer;
  logic       clk = 1'b0;
  logic       sync_reset;
  logic       hold;
  logic       r_eq_0;
  logic [7:0] pm_mem [0:255];
  int         checks   = 0;
  int         failures = 0;

  cu_sequencer_if #(.PC_W(8)) bus ();

  assign bus.pm_data = pm_mem[bus.pm_addr];
  assign bus.hold    = hold;
  assign bus.r_eq_0  = r_eq_0;

  cu_sequencer #(.PC_W(8), .NOP_WORD(8'hC8)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int a = 0; a < 256; a++) pm_mem[a] = 8'hC8;
  endtask

  task automatic do_reset();
    sync_reset = 1'b1;
    step();
    step();
    sync_reset = 1'b0;
  endtask

  task automatic run_until(input logic [7:0] word, input string tag);
    int n = 0;
    while (bus.ir !== word && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (bus.ir !== word) begin
      failures++;
      $display("FAIL %s_timeout ir=%h required=%h", tag, bus.ir, word);
    end
  endtask

  task automatic test_reset();
    fill_nop();
    pm_mem[0] = 8'h14; pm_mem[1] = 8'h8F; pm_mem[2] = 8'hA4;
    pm_mem[3] = 8'hDA; pm_mem[4] = 8'hC8; pm_mem[5] = 8'hCF;
    pm_mem[6] = 8'h75; pm_mem[7] = 8'h65;
    sync_reset = 1'b1;
    step();
    step();
    checks++; if (bus.pm_addr !== 8'h00) begin failures++; $display("FAIL rst_pm_addr got=%h exp=00", bus.pm_addr); end
    checks++; if (bus.ir !== 8'hC8) begin failures++; $display("FAIL rst_ir got=%h exp=c8", bus.ir); end
    checks++; if (bus.reg_en !== 9'h000) begin failures++; $display("FAIL rst_reg_en got=%h exp=000", bus.reg_en); end
    checks++; if ({bus.source_sel, bus.i_sel, bus.x_sel, bus.y_sel} !== {4'd10, 3'b001})
      begin failures++; $display("FAIL rst_nop_ctl got=%h/%b%b%b exp=a/001", bus.source_sel, bus.i_sel, bus.x_sel, bus.y_sel); end
    sync_reset = 1'b0;
    step();
    checks++; if (bus.ir !== 8'h14) begin failures++; $display("FAIL first_ir got=%h exp=14", bus.ir); end
    checks++; if (bus.pm_addr !== 8'h01) begin failures++; $display("FAIL first_pm_addr got=%h exp=01", bus.pm_addr); end
    // 0x14 loads x1 from pm_data
    checks++; if (bus.reg_en !== 9'h002) begin failures++; $display("FAIL load_x1_reg_en got=%h exp=002", bus.reg_en); end
    checks++; if (bus.source_sel !== 4'd8) begin failures++; $display("FAIL load_src got=%0d exp=8", bus.source_sel); end
    checks++; if (bus.nibble_ir !== 4'h4) begin failures++; $display("FAIL nibble got=%h exp=4", bus.nibble_ir); end
  endtask

  task automatic test_decode();
    step(); // 0x8F: move dm -> x1
    checks++; if (bus.source_sel !== 4'd7) begin failures++; $display("FAIL mov_dm_src got=%0d exp=7", bus.source_sel); end
    checks++; if (bus.reg_en !== 9'h042) begin failures++; $display("FAIL mov_dm_reg_en got=%h exp=042", bus.reg_en); end
    checks++; if (bus.i_sel !== 1'b1) begin failures++; $display("FAIL mov_dm_i_sel got=%b exp=1", bus.i_sel); end
    step(); // 0xA4: i_pins -> o_reg
    checks++; if (bus.source_sel !== 4'd9) begin failures++; $display("FAIL mov_pins_src got=%0d exp=9", bus.source_sel); end
    checks++; if (bus.reg_en !== 9'h100) begin failures++; $display("FAIL mov_pins_reg_en got=%h exp=100", bus.reg_en); end
    step(); // 0xDA: ALU x1,y1
    checks++; if ({bus.x_sel, bus.y_sel} !== 2'b11) begin failures++; $display("FAIL alu_xy got=%b%b exp=11", bus.x_sel, bus.y_sel); end
    checks++; if (bus.reg_en !== 9'h010) begin failures++; $display("FAIL alu_reg_en got=%h exp=010", bus.reg_en); end
    checks++; if (bus.source_sel !== 4'd10) begin failures++; $display("FAIL alu_src got=%0d exp=10", bus.source_sel); end
    step(); // 0xC8: NOP
    checks++; if (bus.reg_en !== 9'h000) begin failures++; $display("FAIL nop_c8_reg_en got=%h exp=000", bus.reg_en); end
    step(); // 0xCF: NOP
    checks++; if (bus.reg_en !== 9'h000) begin failures++; $display("FAIL nop_cf_reg_en got=%h exp=000", bus.reg_en); end
    step(); // 0x75: load dm, i increments
    checks++; if (bus.reg_en !== 9'h0C0 || bus.i_sel !== 1'b1)
      begin failures++; $display("FAIL load_dm got=%h/%b exp=0c0/1", bus.reg_en, bus.i_sel); end
    step(); // 0x65: load i
    checks++; if (bus.reg_en !== 9'h040 || bus.i_sel !== 1'b0)
      begin failures++; $display("FAIL load_i got=%h/%b exp=040/0", bus.reg_en, bus.i_sel); end
  endtask

  task automatic test_jump();
    fill_nop();
    pm_mem[8'h25] = 8'hE3; pm_mem[8'h23] = 8'h5A;
    do_reset();
    run_until(8'hE3, "jmp");
    checks++; if (bus.pm_addr !== 8'h26 || bus.reg_en !== 9'h000)
      begin failures++; $display("FAIL jmp_in_ir got=%h/%h exp=26/000", bus.pm_addr, bus.reg_en); end
    step();
    checks++; if (bus.pm_addr !== 8'h23 || bus.ir !== 8'hC8)
      begin failures++; $display("FAIL jmp_bubble got=%h/%h exp=23/c8", bus.pm_addr, bus.ir); end
    step();
    checks++; if (bus.ir !== 8'h5A || bus.pm_addr !== 8'h24 || bus.reg_en !== 9'h020)
      begin failures++; $display("FAIL jmp_target got=%h/%h/%h exp=5a/24/020", bus.ir, bus.pm_addr, bus.reg_en); end

    fill_nop();
    pm_mem[8'hFF] = 8'hE0; pm_mem[8'hF0] = 8'h33;
    do_reset();
    run_until(8'hE0, "jmp_wrap");
    checks++; if (bus.pm_addr !== 8'h00) begin failures++; $display("FAIL jmp_wrap_pc got=%h exp=00", bus.pm_addr); end
    step();
    checks++; if (bus.pm_addr !== 8'hF0 || bus.ir !== 8'hC8)
      begin failures++; $display("FAIL jmp_wrap_bubble got=%h/%h exp=f0/c8", bus.pm_addr, bus.ir); end
    step();
    checks++; if (bus.ir !== 8'h33 || bus.reg_en !== 9'h008)
      begin failures++; $display("FAIL jmp_wrap_target got=%h/%h exp=33/008", bus.ir, bus.reg_en); end

    fill_nop();
    pm_mem[8'hFF] = 8'h24; pm_mem[8'h00] = 8'h14;
    do_reset();
    step(); // consume address 0 first pass
    run_until(8'h24, "fetch_wrap");
    checks++; if (bus.pm_addr !== 8'h00) begin failures++; $display("FAIL fetch_wrap_pc got=%h exp=00", bus.pm_addr); end
    step();
    checks++; if (bus.ir !== 8'h14 || bus.pm_addr !== 8'h01)
      begin failures++; $display("FAIL fetch_wrap_next got=%h/%h exp=14/01", bus.ir, bus.pm_addr); end
  endtask

  task automatic test_jnz();
    fill_nop();
    pm_mem[8'h10] = 8'hF7; pm_mem[8'h17] = 8'h21; pm_mem[8'h11] = 8'h31;
    r_eq_0 = 1'b0;
    do_reset();
    run_until(8'hF7, "jnz_t");
    step();
    checks++; if (bus.pm_addr !== 8'h17 || bus.ir !== 8'hC8)
      begin failures++; $display("FAIL jnz_taken got=%h/%h exp=17/c8", bus.pm_addr, bus.ir); end
    step();
    checks++; if (bus.ir !== 8'h21) begin failures++; $display("FAIL jnz_taken_target got=%h exp=21", bus.ir); end

    r_eq_0 = 1'b1;
    do_reset();
    run_until(8'hF7, "jnz_nt");
    step();
    checks++; if (bus.ir !== 8'h31 || bus.pm_addr !== 8'h12)
      begin failures++; $display("FAIL jnz_not_taken got=%h/%h exp=31/12", bus.ir, bus.pm_addr); end
    r_eq_0 = 1'b0;
  endtask

  task automatic test_hold();
    fill_nop();
    pm_mem[8'h0F] = 8'h14; pm_mem[8'h10] = 8'hF7; pm_mem[8'h17] = 8'h21;
    r_eq_0 = 1'b0;
    do_reset();
    run_until(8'h14, "hold_load");
    hold = 1'b1;
    #1;
    checks++; if (bus.reg_en !== 9'h000 || bus.source_sel !== 4'd8)
      begin failures++; $display("FAIL hold_load_ctl got=%h/%0d exp=000/8", bus.reg_en, bus.source_sel); end
    step();
    checks++; if (bus.ir !== 8'h14 || bus.pm_addr !== 8'h10)
      begin failures++; $display("FAIL hold_load_frozen got=%h/%h exp=14/10", bus.ir, bus.pm_addr); end
    hold = 1'b0;
    step();
    checks++; if (bus.ir !== 8'hF7) begin failures++; $display("FAIL hold_release_ir got=%h exp=f7", bus.ir); end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.pm_addr !== 8'h11 || bus.ir !== 8'hF7 || bus.reg_en !== 9'h000)
        begin failures++; $display("FAIL hold_branch_%0d got=%h/%h/%h exp=11/f7/000", k, bus.pm_addr, bus.ir, bus.reg_en); end
    end
    hold = 1'b0;
    step();
    checks++; if (bus.pm_addr !== 8'h17 || bus.ir !== 8'hC8)
      begin failures++; $display("FAIL hold_branch_taken got=%h/%h exp=17/c8", bus.pm_addr, bus.ir); end
  endtask

  task automatic test_reset_over_hold();
    hold = 1'b1;
    sync_reset = 1'b1;
    step();
    checks++; if (bus.pm_addr !== 8'h00 || bus.ir !== 8'hC8)
      begin failures++; $display("FAIL reset_over_hold got=%h/%h exp=00/c8", bus.pm_addr, bus.ir); end
    sync_reset = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    sync_reset = 1'b1;
    hold       = 1'b0;
    r_eq_0     = 1'b0;
    test_reset();
    test_decode();
    test_jump();
    test_jnz();
    test_hold();
    test_reset_over_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
